// File: rtl/des_expand_mix.sv
// DES round front end: expands the right half R to 48 bits, mixes in the round
// subkey, and buffers the result in a 2-entry FIFO ahead of the S-box stage.
module des_expand_mix (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [47:0] sbox_in,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [47:0] mem [2];
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic        push;
  logic        pop;
  logic [47:0] mix;

  // E table: lane j takes DES bits 4j-4..4j+1, wrapping 0->32 and 33->1.
  // DES bit n of a w-bit word lives at vector index w-n.
  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [47:0] e;
    int          n;
    int          pos;
    e = '0;
    for (int j = 1; j <= 8; j++) begin
      for (int k = 0; k < 6; k++) begin
        n = 4 * j - 4 + k;
        if (n == 0) n = 32;
        else if (n == 33) n = 1;
        pos = 6 * (j - 1) + k + 1;
        e[48 - pos] = r[32 - n];
      end
    end
    return e;
  endfunction

  assign mix       = e_expand(r_in) ^ subkey;
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign sbox_in   = out_valid ? mem[rd_ptr] : 48'h0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; sbox_in masks it whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mix;
  end

endmodule

// File: tb/tb_des_expand_mix.sv
// Directed bench for des_expand_mix: E-table vectors, FIFO backpressure,
// streaming, async reset mid-transfer and flush priority.
module tb_des_expand_mix;

  logic        clk;
  logic        n_rst;
  logic [31:0] r_in;
  logic [47:0] subkey;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [47:0] sbox_in;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;

  des_expand_mix dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .r_in      (r_in),
    .subkey    (subkey),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .sbox_in   (sbox_in),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic rdy, input logic [47:0] d);
    chk({tag, "_valid"}, 48'(out_valid), 48'(v));
    chk({tag, "_ready"}, 48'(in_ready), 48'(rdy));
    chk({tag, "_data"}, sbox_in, d);
  endtask

  // Push one vector into an empty FIFO, check 1-cycle latency, then drain.
  task automatic push_one(input string tag, input logic [31:0] r, input logic [47:0] k,
                          input logic [47:0] exp);
    r_in = r; subkey = k; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; r_in = 32'hDEADBEEF; subkey = 48'hA5A5A5A5A5A5;
    chk_state(tag, 1'b1, 1'b1, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_state({tag, "_drain"}, 1'b0, 1'b1, 48'h0);
  endtask

  typedef struct {
    logic [31:0] r;
    logic [47:0] k;
    logic [47:0] e;
  } vec_t;

  vec_t vecs [5];
  logic [47:0] stream [6];

  initial begin
    checks = 0; errors = 0;
    n_rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    r_in = 32'h0; subkey = 48'h0;

    vecs[0] = '{32'h00000000, 48'h000000000000, 48'h000000000000};
    vecs[1] = '{32'h00000001, 48'h000000000000, 48'h800000000002};
    vecs[2] = '{32'h80000000, 48'hFFFFFFFFFFFF, 48'hBFFFFFFFFFFE};
    vecs[3] = '{32'hF0000000, 48'h123456789ABC, 48'h683456789ABD};
    vecs[4] = '{32'h0000000F, 48'h000000000000, 48'h80000000005E};

    #3;
    chk_state("reset", 1'b0, 1'b1, 48'h0);
    #10 n_rst = 1'b1;
    step();

    // Idle cycle with junk inputs and out_ready on an empty FIFO
    r_in = 32'h12345678; subkey = 48'hFFFF0000FFFF; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_state("idle_empty", 1'b0, 1'b1, 48'h0);

    for (int i = 0; i < 5; i++) push_one($sformatf("vec%0d", i), vecs[i].r, vecs[i].k, vecs[i].e);

    // Backpressure: A, B accepted, C held until space opens
    r_in = 32'h0; out_ready = 1'b0; in_valid = 1'b1;
    subkey = 48'hAAAAAAAAAAAA;
    step();
    subkey = 48'hBBBBBBBBBBBB;
    step();
    chk_state("bp_full", 1'b1, 1'b0, 48'hAAAAAAAAAAAA);
    subkey = 48'hCCCCCCCCCCCC;
    step();
    chk_state("bp_hold", 1'b1, 1'b0, 48'hAAAAAAAAAAAA);
    out_ready = 1'b1;
    step();
    chk_state("bp_out_b", 1'b1, 1'b1, 48'hBBBBBBBBBBBB);
    step();
    in_valid = 1'b0;
    chk_state("bp_out_c", 1'b1, 1'b1, 48'hCCCCCCCCCCCC);
    step();
    out_ready = 1'b0;
    chk_state("bp_empty", 1'b0, 1'b1, 48'h0);

    // Streaming at one result per cycle
    for (int i = 0; i < 6; i++) stream[i] = 48'h010203040506 * 48'(i + 1);
    in_valid = 1'b1; out_ready = 1'b1; r_in = 32'h0;
    for (int i = 0; i < 6; i++) begin
      subkey = stream[i];
      step();
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, stream[i]);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk_state("stream_end", 1'b0, 1'b1, 48'h0);

    // Async reset with two entries buffered
    in_valid = 1'b1; r_in = 32'h0; subkey = 48'h111111111111;
    step();
    subkey = 48'h222222222222;
    step();
    in_valid = 1'b0;
    chk_state("rst_full", 1'b1, 1'b0, 48'h111111111111);
    #2 n_rst = 1'b0;
    #1;
    chk_state("rst_async", 1'b0, 1'b1, 48'h0);
    #2 n_rst = 1'b1;
    step();
    chk_state("rst_after", 1'b0, 1'b1, 48'h0);
    push_one("rst_first", vecs[1].r, vecs[1].k, vecs[1].e);

    // Flush beats a same-cycle push and pop
    in_valid = 1'b1; r_in = 32'h0; subkey = 48'h333333333333;
    step();
    chk_state("fl_one", 1'b1, 1'b1, 48'h333333333333);
    flush = 1'b1; out_ready = 1'b1; subkey = 48'h444444444444;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_state("fl_clear", 1'b0, 1'b1, 48'h0);
    step();
    chk_state("fl_nostore", 1'b0, 1'b1, 48'h0);
    push_one("fl_after", vecs[3].r, vecs[3].k, vecs[3].e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
